fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the instruction address width.
REQ-002 Parameter DATA_W, default 24, SHALL set the instruction word width.
REQ-003 Parameter RESET_PC, default 8'h00, SHALL set the first fetch address after reset.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the reset: asynchronous, active-high.
REQ-006 Port address, output, ADDR_W, SHALL be the instruction memory read address.
REQ-007 Port er, output, 1, SHALL be the instruction memory read enable.
REQ-008 Port data_in, input, DATA_W, SHALL carry memory read data, valid the cycle after er=1 is sampled.
REQ-009 Port instr, output, DATA_W, SHALL be the held instruction word.
REQ-010 Port instr_pc, output, ADDR_W, SHALL be the address instr was fetched from.
REQ-011 Port instr_valid, output, 1, SHALL flag instr/instr_pc valid.
REQ-012 Port instr_ready, input, 1, SHALL be the downstream accept; transfer occurs when instr_valid and instr_ready are both 1.
REQ-013 Port jump_valid, input, 1, SHALL request a redirect of the next fetch.
REQ-014 Port jump_target, input, ADDR_W, SHALL be the redirect address.
REQ-015 Port halt, input, 1, SHALL suspend new fetches while 1.

Function
REQ-016 FSM states SHALL be FETCH, WAIT, VALID, HALTED.
REQ-017 FETCH: SHALL drive er=1, address=pc for exactly one cycle, then enter WAIT.
REQ-018 WAIT: SHALL drive er=0; SHALL capture data_in into instr and pc into instr_pc; SHALL set pc to pc+1 modulo 2^ADDR_W (8'hFF wraps to 8'h00); SHALL enter VALID.
REQ-019 VALID: SHALL drive instr_valid=1; instr and instr_pc SHALL stay stable until transfer.
REQ-020 On transfer with jump_valid=1, pc SHALL load jump_target; otherwise pc is unchanged.
REQ-021 On transfer, next state SHALL be HALTED if halt=1, else FETCH.
REQ-022 jump_valid SHALL be ignored in every cycle without a transfer.
REQ-023 HALTED: er=0 and instr_valid=0; SHALL enter FETCH in the cycle after halt is sampled 0.
REQ-024 halt SHALL NOT abort an in-flight FETCH/WAIT/VALID sequence; it takes effect only at transfer.
REQ-025 Throughput SHALL be one instruction per 3 cycles when instr_ready is held 1; fetch-to-valid latency is 2 cycles.
REQ-026 er SHALL never be 1 in two consecutive cycles.
REQ-027 address SHALL equal pc in every state.

Reset
REQ-028 While rst=1: state=FETCH, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, er=0.
REQ-029 The first er=1 SHALL appear in the first cycle after rst deasserts.
REQ-030 Reset mid-sequence SHALL discard any captured or in-flight instruction without a transfer.

Configuration
REQ-031 With FETCH_PERF_EN defined, output fetch_count (16 bits) SHALL count transfers, reset to 0, and saturate at 16'hFFFF.
REQ-032 Without FETCH_PERF_EN, the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package fetch_pkg SHALL hold the FSM state typedef and the ADDR_W/DATA_W default constants.
REQ-034 The PC register with increment, wrap, and load SHALL be sub-module fetch_pc; the FSM and instruction register stay in fetch_unit.

Verification
REQ-035 Reset release, memory[0]=24'h123456, instr_ready=1 -> er=1 at address 0 in cycle 1; instr=24'h123456, instr_pc=0, instr_valid=1 in cycle 3.
REQ-036 instr_ready=0 for 5 cycles in VALID -> instr and instr_pc stable, er=0, no further fetch; after ready=1, the next er=1 is at address 1.
REQ-037 Transfer at instr_pc=8'h05 with jump_valid=1, jump_target=8'h40 -> next fetch address 8'h40; jump_valid pulsed during WAIT -> ignored.
REQ-038 pc=8'hFF fetched and transferred -> next fetch address 8'h00.
REQ-039 halt=1 during WAIT -> current instruction still delivered, then HALTED with er=0; halt=0 -> er=1 at the next pc one cycle later.
REQ-040 rst asserted during VALID -> instr_valid=0 immediately; after release, fetch restarts at RESET_PC. With FETCH_PERF_EN, 10 transfers -> fetch_count=10.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and FSM state encoding for the instruction fetch unit.
package fetch_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 24;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t ST_FETCH  = 2'd0;
    localparam fetch_state_t ST_WAIT   = 2'd1;
    localparam fetch_state_t ST_VALID  = 2'd2;
    localparam fetch_state_t ST_HALTED = 2'd3;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: increments with natural wrap, or loads a redirect target.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Load wins over increment; the FSM never asserts both together.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher: FETCH -> WAIT -> VALID, with halt/redirect at transfer.
// Optional transfer counter output fetch_count is enabled by defining FETCH_PERF_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] address,
    output logic              er,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt,
`ifdef FETCH_PERF_EN
    output logic [15:0]       fetch_count,
`endif
    output fetch_state_t      dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where instr_valid and instr_ready are both 1.
    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic [DATA_W-1:0] instr_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic [ADDR_W-1:0] pc;
    logic              xfer;

    assign xfer = (state_q == ST_VALID) && instr_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  state_d = ST_WAIT;
            ST_WAIT:   state_d = ST_VALID;
            ST_VALID:  if (instr_ready) state_d = halt ? ST_HALTED : ST_FETCH;
            ST_HALTED: if (!halt) state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_WAIT) begin
                instr_q    <= data_in;
                instr_pc_q <= pc;
            end
        end
    end

    fetch_pc #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (state_q == ST_WAIT),
        .load_i     (xfer && jump_valid),
        .load_val_i (jump_target),
        .pc_o       (pc)
    );

    // State already rests at FETCH during reset, so er is gated by rst to stay quiet until release.
    assign er          = (state_q == ST_FETCH) && !rst;
    assign address     = pc;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == ST_VALID);
    assign dbg_state_o = state_q;

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
        end else if (xfer && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
        end
    end

    assign fetch_count = fetch_cnt_q;
`endif

endmodule
